// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanning matrix keypad controller with per-frame
// debounce, ghost (multi-key) rejection and a first-word-fall-through event FIFO.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   row_n        active-low row drive, at most one row low
//   col_n        active-low column sense (asynchronous, synchronised inside)
//   key_code     FIFO head key index = row*COLS + col
//   key_release  FIFO head event type (0 press, 1 release)
//   key_valid    FIFO non-empty, head fields valid
//   key_ready    consumer accepts head when key_valid=1
//   key_held     a committed key is currently down
//   ghost        last completed frame saw more than one key
//   overflow     sticky: an event was dropped on a full FIFO
module keypad_scanner #(
    parameter int  ROWS       = 4,
    parameter int  COLS       = 4,
    parameter int  SCAN_DIV   = 1000000,
    parameter int  DEBOUNCE   = 4,
    parameter int  FIFO_DEPTH = 4,
    localparam int KW         = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [ROWS-1:0] row_n,
    input  logic [COLS-1:0] col_n,
    output logic [KW-1:0]   key_code,
    output logic            key_release,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            key_held,
    output logic            ghost,
    output logic            overflow
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int SW = $clog2(DEBOUNCE + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_t;
    typedef enum logic {CS_IDLE, CS_PRESS} cstate_t;

    // ---------------- column synchroniser ----------------
    logic [COLS-1:0] col_s1, col_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_s1 <= '1;
            col_s2 <= '1;
        end else begin
            col_s1 <= col_n;
            col_s2 <= col_s1;
        end
    end

    // ---------------- row scan ----------------
    // 'active' holds rows released during reset; the first edge after reset
    // starts the row 0 dwell.
    logic          active;
    logic [RW-1:0] row_idx;
    logic [DW-1:0] dwell;
    logic          dwell_end, frame_end;

    assign dwell_end = active && (dwell == DW'(SCAN_DIV - 1));
    assign frame_end = dwell_end && (row_idx == RW'(ROWS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            row_idx <= '0;
            dwell   <= '0;
        end else if (!active) begin
            active <= 1'b1;
        end else if (dwell_end) begin
            dwell   <= '0;
            row_idx <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    always_comb begin
        row_n = '1;
        if (active) row_n[row_idx] = 1'b0;
    end

    // ---------------- frame accumulation ----------------
    logic [1:0]    row_hits;     // saturates at 2
    logic [CW-1:0] row_col;
    logic [KW-1:0] row_code;
    logic [1:0]    acc_hits;
    logic [KW-1:0] acc_code;
    logic [2:0]    hit_sum;
    logic [1:0]    tot_hits;
    logic [KW-1:0] tot_code;

    always_comb begin
        row_hits = 2'd0;
        row_col  = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (!col_s2[c]) begin
                if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
                row_col = c[CW-1:0];
            end
        end
    end

    assign row_code = KW'(row_idx) * KW'(COLS) + KW'(row_col);
    assign hit_sum  = {1'b0, acc_hits} + {1'b0, row_hits};
    assign tot_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    // Only meaningful when exactly one key was seen in the whole frame.
    assign tot_code = (row_hits != 2'd0) ? row_code : acc_code;

    // ---------------- debounce and commit ----------------
    res_t          res_kind, prev_kind;
    logic [KW-1:0] res_code, prev_code;
    logic [SW-1:0] stab, stab_nx;
    logic          same, differs, do_commit;
    logic          comm_key;
    logic [KW-1:0] comm_code, pend_code;

    always_comb begin
        res_kind = RES_MULTI;
        if (tot_hits == 2'd0)      res_kind = RES_NONE;
        else if (tot_hits == 2'd1) res_kind = RES_KEY;
    end
    assign res_code = tot_code;

    assign same = (res_kind == prev_kind) &&
                  ((res_kind != RES_KEY) || (res_code == prev_code));

    always_comb begin
        stab_nx = SW'(1);
        if (same) stab_nx = (stab == SW'(DEBOUNCE)) ? stab : stab + 1'b1;
        differs = 1'b0;
        case (res_kind)
            RES_NONE: differs = comm_key;
            RES_KEY:  differs = !comm_key || (comm_code != res_code);
            default:  differs = 1'b0;
        endcase
    end

    assign do_commit = frame_end && (stab_nx == SW'(DEBOUNCE)) &&
                       (res_kind != RES_MULTI) && differs;
    assign key_held  = comm_key;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_hits  <= '0;
            acc_code  <= '0;
            prev_kind <= RES_NONE;
            prev_code <= '0;
            stab      <= '0;
            ghost     <= 1'b0;
            comm_key  <= 1'b0;
            comm_code <= '0;
            pend_code <= '0;
        end else begin
            if (dwell_end) begin
                if (frame_end) begin
                    acc_hits <= '0;
                    acc_code <= '0;
                end else begin
                    acc_hits <= tot_hits;
                    acc_code <= tot_code;
                end
            end
            if (frame_end) begin
                prev_kind <= res_kind;
                prev_code <= res_code;
                stab      <= stab_nx;
                ghost     <= (res_kind == RES_MULTI);
            end
            if (do_commit) begin
                comm_key  <= (res_kind == RES_KEY);
                comm_code <= res_code;
                pend_code <= res_code;
            end
        end
    end

    // ---------------- event generation FSM ----------------
    // Key-to-key change emits the release now and the press one cycle later.
    cstate_t       cstate, cstate_nx;
    logic          push, push_rel;
    logic [KW-1:0] push_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cstate <= CS_IDLE;
        else     cstate <= cstate_nx;
    end

    always_comb begin
        cstate_nx = cstate;
        push      = 1'b0;
        push_rel  = 1'b0;
        push_code = '0;
        case (cstate)
            CS_IDLE: begin
                if (do_commit) begin
                    push = 1'b1;
                    if (!comm_key) begin
                        push_code = res_code;
                    end else begin
                        push_rel  = 1'b1;
                        push_code = comm_code;
                        if (res_kind == RES_KEY) cstate_nx = CS_PRESS;
                    end
                end
            end
            CS_PRESS: begin
                push      = 1'b1;
                push_code = pend_code;
                cstate_nx = CS_IDLE;
            end
            default: cstate_nx = CS_IDLE;
        endcase
    end

    // ---------------- event FIFO (first-word-fall-through) ----------------
    logic [KW:0]   mem [FIFO_DEPTH];
    logic [KW:0]   head;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nx;
    logic [AW:0]   count, remain;
    logic          full, pop, wr_en;

    assign key_valid   = (count != '0);
    assign full        = (count == (AW+1)'(FIFO_DEPTH));
    assign pop         = key_valid && key_ready;
    assign wr_en       = push && (!full || pop);
    assign rd_nx       = rd_ptr + AW'(pop);
    assign remain      = count - (AW+1)'(pop);
    assign key_code    = head[KW-1:0];
    assign key_release = head[KW];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {push_rel, push_code};
    end

    // head is a register so it keeps the last value once the FIFO drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head     <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_nx;
            count  <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
            if (push && full && !pop) overflow <= 1'b1;
            if (remain != '0)  head <= mem[rd_nx];
            else if (wr_en)    head <= {push_rel, push_code};
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized bench for keypad_scanner with a queue-based
// reference model of frames, debounce, commits and the event FIFO.
module tb_keypad_scanner;
    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int SCAN_DIV   = 4;
    localparam int DEBOUNCE   = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int KW         = $clog2(ROWS * COLS);
    localparam int NKEYS      = ROWS * COLS;
    localparam int FRAME      = ROWS * SCAN_DIV;

    typedef struct {
        int code;
        bit rel;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [ROWS-1:0] row_n;
    logic [COLS-1:0] col_n;
    logic [KW-1:0]   key_code;
    logic            key_release, key_valid, key_held, ghost, overflow;
    logic            key_ready = 1'b1;
    logic [NKEYS-1:0] pressed = '0;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
        .key_code(key_code), .key_release(key_release), .key_valid(key_valid),
        .key_ready(key_ready), .key_held(key_held), .ghost(ghost),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_n = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!row_n[r] && pressed[r*COLS + c]) col_n[c] = 1'b0;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Results: -1 no key, -2 several keys, otherwise the key index.
    int  k = -1, frames = 0, committed = -1, prev = -1, stab = 0, pend = -1;
    int  last_code = 0;
    bit  last_rel = 1'b0, m_ovf = 1'b0, m_ghost = 1'b0;
    ev_t q[$];

    function automatic int frame_result();
        int n = 0;
        int idx = -1;
        for (int i = 0; i < NKEYS; i++)
            if (pressed[i]) begin
                n++;
                idx = i;
            end
        if (n == 0) return -1;
        if (n == 1) return idx;
        return -2;
    endfunction

    task automatic push_ev(input int code, input bit rel);
        ev_t e;
        if (q.size() >= FIFO_DEPTH) begin
            m_ovf = 1'b1;
        end else begin
            e.code = code;
            e.rel  = rel;
            q.push_back(e);
        end
    endtask

    initial begin
        int res;
        bit rdy_s, rst_s;
        logic [ROWS-1:0] er;
        forever begin
            @(posedge clk);
            rdy_s = key_ready;
            rst_s = rst;
            if (rst_s) begin
                k = -1; committed = -1; prev = -1; stab = 0; pend = -1;
                last_code = 0; last_rel = 1'b0; m_ovf = 1'b0; m_ghost = 1'b0;
                q.delete();
            end else begin
                k++;
                if (q.size() > 0 && rdy_s) q.delete(0);
                if (pend >= 0) begin
                    push_ev(pend, 1'b0);
                    pend = -1;
                end
                if (k > 0 && k % FRAME == 0) begin
                    res = frame_result();
                    frames++;
                    if (res == prev) stab = (stab < DEBOUNCE) ? stab + 1 : stab;
                    else             stab = 1;
                    prev    = res;
                    m_ghost = (res == -2);
                    if (stab == DEBOUNCE && res != -2 && res != committed) begin
                        if (committed == -1) begin
                            push_ev(res, 1'b0);
                        end else begin
                            push_ev(committed, 1'b1);
                            if (res >= 0) pend = res;
                        end
                        committed = res;
                    end
                end
                if (q.size() > 0) begin
                    last_code = q[0].code;
                    last_rel  = q[0].rel;
                end
            end
            #1;
            er = '1;
            if (!rst_s) er[(k / SCAN_DIV) % ROWS] = 1'b0;
            check("row_n",       int'(row_n),       int'(er));
            check("key_valid",   int'(key_valid),   (q.size() > 0) ? 1 : 0);
            check("key_code",    int'(key_code),    last_code);
            check("key_release", int'(key_release), int'(last_rel));
            check("key_held",    int'(key_held),    (committed >= 0) ? 1 : 0);
            check("ghost",       int'(ghost),       int'(m_ghost));
            check("overflow",    int'(overflow),    int'(m_ovf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_frames(input int n, input bit rnd);
        int target;
        int budget;
        target = frames + n;
        budget = (n + 2) * FRAME;
        while (frames < target && budget > 0) begin
            @(negedge clk);
            if (rnd) key_ready = 1'($urandom_range(0, 1));
            budget--;
        end
        if (frames < target) check("frame_wait_budget", frames, target);
    endtask

    task automatic set_keys(input int a, input int b);
        pressed = '0;
        if (a >= 0) pressed[a] = 1'b1;
        if (b >= 0) pressed[b] = 1'b1;
    endtask

    task automatic check_head(input string name, input int code, input int rel);
        check({name, "_valid"}, int'(key_valid), 1);
        check({name, "_code"},  int'(key_code),  code);
        check({name, "_rel"},   int'(key_release), rel);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_code[4];
        int exp_rel[4];
        int sel, a, b;
        bit found;
        exp_code = '{1, 1, 2, 2};
        exp_rel  = '{0, 1, 0, 1};

        repeat (3) @(negedge clk);
        check("rst_row_n", int'(row_n), 15);
        check("rst_valid", int'(key_valid), 0);
        check("rst_code",  int'(key_code), 0);
        check("rst_held",  int'(key_held), 0);
        rst = 1'b0;

        wait_frames(1, 1'b0);
        set_keys(9, -1);
        wait_frames(2, 1'b0);
        check_head("press9", 9, 0);
        check("press9_held", int'(key_held), 1);
        wait_frames(2, 1'b0);

        set_keys(-1, -1);
        wait_frames(2, 1'b0);
        check_head("rel9", 9, 1);
        check("rel9_held", int'(key_held), 0);
        wait_frames(1, 1'b0);

        set_keys(3, -1);
        wait_frames(2, 1'b0);
        check_head("press3", 3, 0);

        set_keys(5, 6);
        wait_frames(1, 1'b0);
        check("ghost_set", int'(ghost), 1);
        wait_frames(2, 1'b0);
        check("ghost_hold", int'(ghost), 1);
        check("ghost_noev", int'(key_valid), 0);
        check("ghost_held", int'(key_held), 1);
        set_keys(3, -1);
        wait_frames(1, 1'b0);
        check("ghost_clr", int'(ghost), 0);
        wait_frames(1, 1'b0);

        set_keys(12, -1);
        wait_frames(2, 1'b0);
        check_head("swap_rel3", 3, 1);
        @(negedge clk);
        check_head("swap_press12", 12, 0);
        set_keys(-1, -1);
        wait_frames(2, 1'b0);
        check_head("rel12", 12, 1);
        wait_frames(1, 1'b0);

        key_ready = 1'b0;
        set_keys(1, -1);
        wait_frames(2, 1'b0);
        set_keys(2, -1);
        wait_frames(2, 1'b0);
        set_keys(7, -1);
        wait_frames(2, 1'b0);
        set_keys(-1, -1);
        wait_frames(2, 1'b0);
        check("ovf_set", int'(overflow), 1);
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_head($sformatf("drain%0d", i), exp_code[i], exp_rel[i]);
            @(negedge clk);
        end
        check("drain_empty", int'(key_valid), 0);
        check("drain_hold_code", int'(key_code), 2);
        check("drain_hold_rel", int'(key_release), 1);
        check("ovf_sticky", int'(overflow), 1);

        set_keys(9, -1);
        wait_frames(2, 1'b0);
        check("pre_rst_held", int'(key_held), 1);
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk);
            if (row_n == 4'b1011) found = 1'b1;
        end
        check("row2_reached", int'(found), 1);
        @(negedge clk);
        check("mid_row2", int'(row_n), 11);
        rst = 1'b1;
        #1;
        check("arst_row_n", int'(row_n), 15);
        check("arst_valid", int'(key_valid), 0);
        check("arst_held",  int'(key_held), 0);
        check("arst_ghost", int'(ghost), 0);
        check("arst_ovf",   int'(overflow), 0);
        check("arst_code",  int'(key_code), 0);
        check("arst_rel",   int'(key_release), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_row_after_rst", int'(row_n), 14);

        repeat (40) begin
            sel = $urandom_range(0, 3);
            a = $urandom_range(0, NKEYS - 1);
            b = $urandom_range(0, NKEYS - 1);
            if (sel == 0)      set_keys(-1, -1);
            else if (sel == 2) set_keys(a, b);
            else               set_keys(a, -1);
            wait_frames($urandom_range(1, 3), 1'b1);
        end
        key_ready = 1'b1;
        set_keys(-1, -1);
        wait_frames(3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
